// File: rtl/wallace_mult_sched.sv
// Shared 53x53 Wallace-tree mantissa multiplier with a round-robin scheduler.
// Two requesters compete for one tree. The winning operands are registered
// and held while the tree settles. The carry-save pair is then summed, and
// the product is returned on a valid/ready channel tagged with the requester id.

// Combinational Wallace tree. The 53 partial-product rows are reduced with
// 3:2 compressors, one layer at a time, until two rows remain. The outputs
// are index-reversed: c0[0]/c1[0] carry product bit 105.
module wallace (
    input  logic [52:0]  a,
    input  logic [52:0]  b,
    output logic [0:105] c0,
    output logic [0:105] c1
);

    function automatic logic [211:0] reduce(input logic [52:0] x_a, input logic [52:0] x_b);
        logic [105:0] rows [53];
        logic [105:0] nxt  [53];
        logic [105:0] x, y, z, maj;
        int unsigned  n, q, r;
        for (int unsigned i = 0; i < 53; i++) begin
            rows[6'(i)] = ({53'd0, x_a} & {106{x_b[6'(i)]}}) << i;
        end
        n = 53;
        // 53 rows need nine layers to reach two; the spare pass is a no-op.
        for (int unsigned l = 0; l < 10; l++) begin
            if (n > 2) begin
                q = n / 3;
                r = n - 3 * q;
                for (int unsigned i = 0; i < 53; i++) begin
                    nxt[6'(i)] = '0;
                end
                for (int unsigned g = 0; g < 18; g++) begin
                    if (g < q) begin
                        x   = rows[6'(3 * g)];
                        y   = rows[6'(3 * g + 1)];
                        z   = rows[6'(3 * g + 2)];
                        maj = (x & y) | (x & z) | (y & z);
                        nxt[6'(2 * g)]     = x ^ y ^ z;
                        nxt[6'(2 * g + 1)] = {maj[104:0], 1'b0};
                    end
                end
                for (int unsigned j = 0; j < 2; j++) begin
                    if (j < r) begin
                        nxt[6'(2 * q + j)] = rows[6'(3 * q + j)];
                    end
                end
                n    = 2 * q + r;
                rows = nxt;
            end
        end
        return {rows[0], rows[1]};
    endfunction

    // Reduce the partial products to one carry-save pair.
    always_comb begin
        {c0, c1} = reduce(a, b);
    end

endmodule

module wallace_mult_sched #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [52:0]  req0_a,
    input  logic [52:0]  req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [52:0]  req1_a,
    input  logic [52:0]  req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [105:0] rsp_p,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, SUM, HOLD} state_t;

    state_t       state;
    state_t       state_nx;
    logic [52:0]  opa;
    logic [52:0]  opb;
    logic [3:0]   cnt;
    logic         cur_id;
    logic         last_id;
    logic         grant0;
    logic         grant1;
    logic [0:105] c0;
    logic [0:105] c1;

    wallace u_tree (
        .a  (opa),
        .b  (opb),
        .c0 (c0),
        .c1 (c1)
    );

    // Round-robin grant: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_id);
        grant1 = req1_valid && (!req0_valid || !last_id);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant0 || grant1) state_nx = SETTLE;
            SETTLE:  if (cnt == 4'd0)      state_nx = SUM;
            SUM:                           state_nx = HOLD;
            HOLD:    if (rsp_ready)        state_nx = IDLE;
            default:                       state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state; ready is also held low while reset is asserted.
    always_comb begin
        req0_ready = rst_n && (state == IDLE) && grant0;
        req1_ready = rst_n && (state == IDLE) && grant1;
        rsp_valid  = (state == HOLD);
        busy       = (state != IDLE);
    end

    // Datapath: operand capture on accept, settle countdown, final carry-propagate add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa     <= '0;
            opb     <= '0;
            cnt     <= '0;
            cur_id  <= 1'b0;
            last_id <= 1'b1;
            rsp_p   <= '0;
            rsp_id  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        opa     <= grant1 ? req1_a : req0_a;
                        opb     <= grant1 ? req1_b : req0_b;
                        cur_id  <= grant1;
                        last_id <= grant1;
                        cnt     <= 4'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                SUM: begin
                    rsp_p  <= c0 + c1;
                    rsp_id <= cur_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wallace_mult_sched.sv
// Directed bench for wallace_mult_sched with SETTLE_CYCLES = 2.
module tb_wallace_mult_sched;

    localparam int unsigned S = 2;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready;
    logic [52:0]  req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [52:0]  req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [105:0] rsp_p;

    int n_cmp = 0;
    int n_bad = 0;

    wallace_mult_sched #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_p      (rsp_p),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present one request, wait for its ready, complete the handshake, drop valid.
    task automatic send(input bit id, input logic [52:0] a, input logic [52:0] b, output bit ok);
        ok = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        for (int k = 0; k < 50 && !ok; k++) begin
            #1;
            if (id ? req1_ready : req0_ready) ok = 1'b1;
            step;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Wait for a response and take it (rsp_ready is high).
    task automatic get(output logic [105:0] p, output logic rid, output bit ok);
        ok = 1'b0;
        p = '0;
        rid = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                p = rsp_p;
                rid = rsp_id;
            end
            step;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 53'd3; req0_b = 53'd3;
        req1_valid = 1'b1; req1_a = 53'd4; req1_b = 53'd4;
        rsp_ready = 1'b1;
        step;
        step;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_bad++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        n_cmp++;
        if ({rsp_valid, rsp_id, busy} !== 3'b000 || rsp_p !== 106'd0) begin
            n_bad++; $display("FAIL reset_outputs: got v=%b id=%b busy=%b p=%0h want all 0",
                              rsp_valid, rsp_id, busy, rsp_p);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_contention;
        logic [105:0] p;
        logic rid;
        bit ok;
        bit g;
        req0_valid = 1'b1; req0_a = 53'd7;  req0_b = 53'd9;
        req1_valid = 1'b1; req1_a = 53'd11; req1_b = 53'd13;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ok = 1'b0;
            g = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                #1;
                if (req0_ready || req1_ready) begin
                    ok = 1'b1;
                    g = req1_ready;
                    n_cmp++;
                    if (req0_ready && req1_ready) begin
                        n_bad++; $display("FAIL contend_one_ready: got both ready want exactly one");
                    end
                end
                step;
            end
            n_cmp++;
            if (!ok || g !== 1'(i % 2)) begin
                n_bad++; $display("FAIL contend_grant%0d: got ok=%b id=%b want id=%0d", i, ok, g, i % 2);
            end
            get(p, rid, ok);
            n_cmp++;
            if (!ok || p !== ((i % 2) ? 106'd143 : 106'd63) || rid !== 1'(i % 2)) begin
                n_bad++; $display("FAIL contend_rsp%0d: got ok=%b p=%0d id=%b want p=%0d id=%0d",
                                  i, ok, p, rid, (i % 2) ? 143 : 63, i % 2);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step;
    endtask

    task automatic test_single;
        bit ok;
        bit busy_ok;
        int e;
        logic [105:0] p;
        logic rid;
        rsp_ready = 1'b1;
        send(1'b0, 53'd3, 53'd5, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_accept: got no ready want ready"); end
        // Now just after the accept edge; count edges until rsp_valid is seen.
        e = 0;
        busy_ok = 1'b1;
        while (!rsp_valid && e < 30) begin
            if (!busy) busy_ok = 1'b0;
            step;
            e++;
        end
        p = rsp_p;
        rid = rsp_id;
        n_cmp++;
        if (e + 1 != int'(S) + 2) begin
            n_bad++; $display("FAIL single_latency: got handshake at accept+%0d want accept+%0d", e + 1, S + 2);
        end
        n_cmp++;
        if (p !== 106'd15 || rid !== 1'b0) begin
            n_bad++; $display("FAIL single_product: got p=%0d id=%b want p=15 id=0", p, rid);
        end
        n_cmp++;
        if (!busy_ok || !busy) begin
            n_bad++; $display("FAIL single_busy_high: got busy low before response want high");
        end
        step;
        n_cmp++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_busy_drop: got busy=%b v=%b want 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_full_scale;
        bit ok, ok2;
        logic [105:0] p;
        logic [105:0] expv;
        logic rid;
        expv = 106'd1 - (106'd1 << 54);
        send(1'b1, {53{1'b1}}, {53{1'b1}}, ok);
        get(p, rid, ok2);
        n_cmp++;
        if (!ok || !ok2 || p !== expv || rid !== 1'b1) begin
            n_bad++; $display("FAIL full_scale: got ok=%b%b p=%0h id=%b want p=%0h id=1", ok, ok2, p, rid, expv);
        end
        send(1'b0, 53'd0, {53{1'b1}}, ok);
        get(p, rid, ok2);
        n_cmp++;
        if (!ok || !ok2 || p !== 106'd0 || rid !== 1'b0) begin
            n_bad++; $display("FAIL zero_operand: got ok=%b%b p=%0h id=%b want p=0 id=0", ok, ok2, p, rid);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [105:0] p0;
        logic rid0;
        logic [105:0] p;
        logic rid;
        rsp_ready = 1'b0;
        send(1'b0, 53'd3, 53'd5, ok);
        for (int k = 0; k < 20 && !rsp_valid; k++) step;
        p0 = rsp_p;
        rid0 = rsp_id;
        n_cmp++;
        if (rsp_valid !== 1'b1 || p0 !== 106'd15) begin
            n_bad++; $display("FAIL bp_first: got v=%b p=%0d want v=1 p=15", rsp_valid, p0);
        end
        req0_valid = 1'b1; req0_a = 53'd7; req0_b = 53'd9;
        for (int i = 0; i < 5; i++) begin
            step;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_p !== 106'd15 || rsp_id !== 1'b0 || req0_ready !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold%0d: got v=%b p=%0d id=%b rdy=%b want v=1 p=15 id=0 rdy=0",
                                  i, rsp_valid, rsp_p, rsp_id, req0_ready);
            end
        end
        rsp_ready = 1'b1;
        step;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req0_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req0_ready);
        end
        step;
        req0_valid = 1'b0;
        get(p, rid, ok);
        n_cmp++;
        if (!ok || p !== 106'd63 || rid !== 1'b0) begin
            n_bad++; $display("FAIL bp_next: got ok=%b p=%0d id=%b want p=63 id=0", ok, p, rid);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen;
        logic [105:0] p;
        logic rid;
        send(1'b0, 53'd7, 53'd9, ok);
        step;
        rst_n = 1'b0;
        req1_valid = 1'b1; req1_a = 53'd2; req1_b = 53'd2;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, busy, req0_ready, req1_ready} !== 5'b00000 || rsp_p !== 106'd0) begin
            n_bad++; $display("FAIL mid_reset_outputs: got v=%b id=%b busy=%b rdy=%b%b p=%0d want all 0",
                              rsp_valid, rsp_id, busy, req0_ready, req1_ready, rsp_p);
        end
        step;
        step;
        rst_n = 1'b1;
        req1_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid) seen = 1'b1;
            step;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL mid_reset_dropped: got a response want none"); end
        send(1'b1, 53'd2, 53'd2, ok);
        get(p, rid, ok);
        n_cmp++;
        if (!ok || p !== 106'd4 || rid !== 1'b1) begin
            n_bad++; $display("FAIL mid_reset_after: got ok=%b p=%0d id=%b want p=4 id=1", ok, p, rid);
        end
    endtask

    task automatic test_random;
        bit ok;
        bit done;
        bit id;
        logic [63:0] ra, rb;
        logic [52:0] a, b;
        logic [105:0] expv;
        for (int i = 0; i < 30; i++) begin
            id = 1'($urandom_range(0, 1));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            a = ra[52:0];
            b = rb[52:0];
            expv = {53'd0, a} * {53'd0, b};
            send(id, a, b, ok);
            done = 1'b0;
            for (int k = 0; k < 80 && !done; k++) begin
                rsp_ready = 1'($urandom_range(0, 1));
                #1;
                if (rsp_valid && rsp_ready) begin
                    done = 1'b1;
                    n_cmp++;
                    if (rsp_p !== expv || rsp_id !== id) begin
                        n_bad++; $display("FAIL random%0d: got p=%0h id=%b want p=%0h id=%b",
                                          i, rsp_p, rsp_id, expv, id);
                    end
                end
                step;
            end
            if (!ok || !done) begin
                n_cmp++;
                n_bad++; $display("FAIL random%0d_timeout: got accept=%b rsp=%b want 1 1", i, ok, done);
            end
        end
        rsp_ready = 1'b1;
        step;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        test_reset;
        test_contention;
        test_single;
        test_full_scale;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
